cpu_pc_ctrl: RTL and testbench
==============================

CPU_PC_CTRL -- requirements
Module: cpu_pc_ctrl

Interface
REQ-001 Parameter WIDTH, 32, address width in bits (>= 8).
REQ-002 Parameter RESET_VECTOR, 32'hBFC00000, first fetch address after reset.
REQ-003 Parameter EXC_VECTOR, 32'hBFC00380, redirect address on exception or misaligned target.
REQ-004 Parameter STEP, 4, sequential increment in bytes.
REQ-005 clk  input  1  single clock, all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high; state reset on any posedge where high, may be held for multiple cycles.
REQ-007 wen  input  1  advance enable; PC iterates only on posedges where high.
REQ-008 b_cond_met  input  1  branch/jump taken by the instruction currently at pc_o.
REQ-009 b_target  input  WIDTH  branch/jump destination, sampled with b_cond_met.
REQ-010 exc_req  input  1  exception redirect request.
REQ-011 pc_o  output  WIDTH  current fetch address (registered).
REQ-012 delay_slot_o  output  1  high while pc_o addresses a branch delay slot.
REQ-013 halted_o  output  1  high once the CPU has jumped to address 0.
REQ-014 addr_err_o  output  1  one-cycle pulse on a misaligned redirect.

Function
REQ-015 The block SHALL implement FSM states RUN, SLOT, HALT; delay_slot_o = (state==SLOT), halted_o = (state==HALT).
REQ-016 On a wen edge in RUN with b_cond_met=0, the block SHALL set pc_o <= pc_o+STEP (mod 2^WIDTH, wrap-around silent) and stay in RUN.
REQ-017 On a wen edge in RUN with b_cond_met=1, the block SHALL latch b_target, set pc_o <= pc_o+STEP and enter SLOT.
REQ-018 On a wen edge in SLOT, the block SHALL set pc_o <= latched target and enter RUN, or HALT if the latched target equals 0.
REQ-019 b_cond_met asserted in SLOT SHALL be ignored (branch in delay slot has no effect).
REQ-020 If the latched target has bits [1:0] != 0, the SLOT->redirect edge SHALL load EXC_VECTOR instead, enter RUN, and pulse addr_err_o for exactly one cycle.
REQ-021 With wen=0 the block SHALL hold pc_o, state and latched target unchanged.
REQ-022 exc_req high on a posedge (independent of wen) in RUN or SLOT SHALL load EXC_VECTOR, discard any pending target, and enter RUN.
REQ-023 Priority SHALL be reset > exc_req > HALT hold > wen-advance.
REQ-024 In HALT, pc_o SHALL stay 0 and wen, b_cond_met and exc_req SHALL be ignored until reset.
REQ-025 Each state transition SHALL take exactly one cycle; outputs SHALL be registered with no combinational input-to-output path.

Reset
REQ-026 Any posedge with reset=1 SHALL set pc_o=RESET_VECTOR, state=RUN, latched target=0, delay_slot_o=0, halted_o=0, addr_err_o=0, overriding all other inputs.
REQ-027 Reset asserted mid-SLOT SHALL cancel the pending branch; the first fetch after reset deasserts SHALL be RESET_VECTOR.

Structure
REQ-028 The state enum and the default vector constants SHALL reside in the shared CPU package (cpu_pkg) for reuse by the decoder and bench.
REQ-029 The block SHALL be a single module with no sub-modules; next-state logic in one combinational process, state in one clocked process.

Verification
REQ-030 Reset 2 cycles, then 3 wen pulses -> pc_o sequence BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-031 At pc_o=BFC00004, b_cond_met=1, b_target=BFC00100 -> next BFC00008 with delay_slot_o=1, then BFC00100 with delay_slot_o=0.
REQ-032 Branch to 00000000 -> delay slot fetched, then pc_o=0, halted_o=1; further wen/exc_req leave pc_o=0 until reset.
REQ-033 Branch to BFC00102 -> after slot, pc_o=BFC00380, addr_err_o high for one cycle only.
REQ-034 exc_req during SLOT with wen=0 -> pc_o=BFC00380, state RUN, pending target never taken.
REQ-035 Reset asserted during SLOT, wen held 0 between steps -> pc_o=BFC00000, delay_slot_o=0, pc_o frozen while wen=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and default vectors for the PC controller, decoder and bench
package cpu_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_SLOT, ST_HALT} pc_state_e;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC00380;
  localparam int          STEP_DEF         = 4;
endpackage

// File: rtl/cpu_pc_ctrl.sv
// cpu_pc_ctrl: program counter sequencer with one branch delay slot, exception redirect and halt-at-zero
module cpu_pc_ctrl
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
  parameter int               STEP         = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  logic             b_cond_met,
  input  logic [WIDTH-1:0] b_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc_o,
  output logic             delay_slot_o,
  output logic             halted_o,
  output logic             addr_err_o
);
  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             err_q, err_d;
  // state register; reset cancels any pending branch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end
  // next state: exception beats halt-hold beats wen-advance; halt ignores everything but reset
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    err_d   = 1'b0;
    if (state_q != ST_HALT && exc_req) begin
      state_d = ST_RUN;
      pc_d    = EXC_VECTOR;
      tgt_d   = '0;
    end else if (state_q == ST_RUN && wen) begin
      pc_d    = pc_q + WIDTH'(STEP);
      state_d = b_cond_met ? ST_SLOT : ST_RUN;
      tgt_d   = b_cond_met ? b_target : tgt_q;
    end else if (state_q == ST_SLOT && wen) begin
      err_d   = tgt_q[1:0] != 2'b00;
      pc_d    = err_d ? EXC_VECTOR : tgt_q;
      state_d = (!err_d && tgt_q == '0) ? ST_HALT : ST_RUN;
    end
  end
  // outputs decode registered state only
  always_comb begin
    pc_o         = pc_q;
    delay_slot_o = state_q == ST_SLOT;
    halted_o     = state_q == ST_HALT;
    addr_err_o   = err_q;
  end
endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// tb_cpu_pc_ctrl: directed vector table plus randomized run against a behavioural PC model
module tb_cpu_pc_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wen = 1'b0;
  logic        b_cond_met = 1'b0;
  logic [31:0] b_target = '0;
  logic        exc_req = 1'b0;
  logic [31:0] pc_o;
  logic        delay_slot_o, halted_o, addr_err_o;
  int          checks = 0;
  int          failures = 0;

  cpu_pc_ctrl dut (
    .clk(clk), .reset(reset), .wen(wen), .b_cond_met(b_cond_met), .b_target(b_target),
    .exc_req(exc_req), .pc_o(pc_o), .delay_slot_o(delay_slot_o), .halted_o(halted_o),
    .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, w, b, e;
    logic [31:0] t;
    logic [31:0] pc;
    logic        ds, hl, er;
  } vec_t;
  vec_t vecs[$];

  // behavioural model: a fetch address, a "next fetch is the delay slot" flag, a halted flag
  logic [31:0] m_pc = 32'hBFC00000;
  logic [31:0] m_dest = '0;
  bit          m_in_slot = 0, m_halted = 0, m_err = 0;

  task automatic model(input logic r, w, b, e, input logic [31:0] t);
    m_err = 0;
    if (r) begin
      m_pc = 32'hBFC00000; m_in_slot = 0; m_halted = 0; m_dest = '0;
    end else if (m_halted) begin
    end else if (e) begin
      m_pc = 32'hBFC00380; m_in_slot = 0;
    end else if (w && m_in_slot) begin
      m_in_slot = 0;
      if (m_dest % 4 != 0) begin
        m_pc = 32'hBFC00380; m_err = 1;
      end else begin
        m_pc = m_dest; m_halted = (m_dest == 0);
      end
    end else if (w) begin
      m_pc = m_pc + 4;
      if (b) begin
        m_dest = t; m_in_slot = 1;
      end
    end
  endtask

  task automatic step(input logic r, w, b, e, input logic [31:0] t);
    reset = r; wen = w; b_cond_met = b; exc_req = e; b_target = t;
    @(posedge clk);
    model(r, w, b, e, t);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic ds, hl, er);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".delay_slot"}, 32'(delay_slot_o), 32'(ds));
    chk({tag, ".halted"}, 32'(halted_o), 32'(hl));
    chk({tag, ".addr_err"}, 32'(addr_err_o), 32'(er));
  endtask

  task automatic add(input logic r, w, b, e, input logic [31:0] t, input logic [31:0] pc,
                     input logic ds, hl, er);
    vec_t v;
    v.r = r; v.w = w; v.b = b; v.e = e; v.t = t; v.pc = pc; v.ds = ds; v.hl = hl; v.er = er;
    vecs.push_back(v);
  endtask

  initial begin
    //  r  w  b  e  target        pc            ds hl er
    add(1, 0, 0, 0, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(1, 1, 1, 1, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC00004, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC00008, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC0000C, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC00004, 0, 0, 0);
    add(0, 1, 1, 0, 32'hBFC00100, 32'hBFC00008, 1, 0, 0);
    add(0, 1, 1, 0, 32'h12345678, 32'hBFC00100, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'hBFC00100, 0, 0, 0);
    add(0, 1, 1, 0, 32'hBFC00102, 32'hBFC00104, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC00380, 0, 0, 1);
    add(0, 0, 0, 0, 32'h0,        32'hBFC00380, 0, 0, 0);
    add(0, 1, 1, 0, 32'hBFC00200, 32'hBFC00384, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0,        32'hBFC00380, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC00384, 0, 0, 0);
    add(0, 1, 1, 0, 32'hBFC00300, 32'hBFC00388, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'hBFC00388, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(0, 0, 1, 0, 32'hBFC00300, 32'hBFC00000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hBFC00004, 0, 0, 0);
    add(0, 1, 1, 0, 32'h00000000, 32'hBFC00008, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'h00000000, 0, 1, 0);
    add(0, 1, 1, 1, 32'hBFC00100, 32'h00000000, 0, 1, 0);
    add(0, 0, 0, 1, 32'h0,        32'h00000000, 0, 1, 0);
    add(1, 0, 0, 0, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(0, 1, 1, 1, 32'hBFC00010, 32'hBFC00380, 0, 0, 0);
    add(1, 1, 0, 1, 32'h0,        32'hBFC00000, 0, 0, 0);
    add(0, 1, 1, 0, 32'hFFFFFFFC, 32'hBFC00004, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'hFFFFFFFC, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'h00000000, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0,        32'h00000004, 0, 0, 0);
    #2;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].w, vecs[i].b, vecs[i].e, vecs[i].t);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ds, vecs[i].hl, vecs[i].er);
    end
    // misaligned redirect with wen held high: error pulse lasts one cycle only
    step(1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 32'hBFC00101);
    chk_all("misalign.slot", 32'hBFC00004, 1, 0, 0);
    step(0, 1, 0, 0, 32'h0);
    chk_all("misalign.redirect", 32'hBFC00380, 0, 0, 1);
    step(0, 1, 0, 0, 32'h0);
    chk_all("misalign.after", 32'hBFC00384, 0, 0, 0);
    // randomized run against the model
    step(1, 0, 0, 0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic        r, w, b, e;
      logic [31:0] t;
      int          sel;
      r = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 19);
      t = $urandom;
      t = (sel == 0) ? 32'h0 : (sel < 4) ? t : (t & 32'hFFFFFFFC);
      step(r, w, b, e, t);
      chk_all($sformatf("rnd%0d", n), m_pc, m_in_slot, m_halted, m_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
